fm_sweep_sequencer: RTL and testbench

//  Sequences the FM modulator's carrier control word (ctr_ctrl) and deviation

---
 rtl/fm_sweep_pkg.sv | 10 +
 rtl/fm_sweep_sequencer_if.sv | 24 ++
 rtl/fm_dwell_counter.sv | 20 ++
 rtl/fm_sweep_sequencer.sv | 109 ++++++++++
 tb/tb_fm_sweep_sequencer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fm_sweep_pkg.sv
// fm_sweep_pkg: widths, FSM state and sweep phase types for the FM sweep sequencer
package fm_sweep_pkg;
  localparam int FW = 32;
  localparam int DW = 8;
  localparam int CW = 16;
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE} state_t;
`ifdef SWEEP_PINGPONG_EN
  typedef enum logic {PH_UP, PH_DOWN} phase_t;
`endif
endpackage

// File: rtl/fm_sweep_sequencer_if.sv
// fm_sweep_sequencer_if: host config/control in, FM modulator control word and status out
interface fm_sweep_sequencer_if;
  import fm_sweep_pkg::*;
  logic          start;
  logic          abort;
  logic [FW-1:0] start_freq;
  logic [FW-1:0] step_freq;
  logic [CW-1:0] num_steps;
  logic [CW-1:0] dwell;
  logic [DW-1:0] dev_in;
  logic [FW-1:0] ctr_ctrl;
  logic [DW-1:0] deviation;
  logic          busy;
  logic          step_strobe;
  logic          done;
  modport master (
    output start, abort, start_freq, step_freq, num_steps, dwell, dev_in,
    input  ctr_ctrl, deviation, busy, step_strobe, done
  );
  modport slave (
    input  start, abort, start_freq, step_freq, num_steps, dwell, dev_in,
    output ctr_ctrl, deviation, busy, step_strobe, done
  );
endinterface

// File: rtl/fm_dwell_counter.sv
// fm_dwell_counter: loadable down-counter holding max(load_val,1)-1, zero flag when expired
module fm_dwell_counter
  import fm_sweep_pkg::*;
#(
  parameter int W = CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= (load_val == '0) ? '0 : load_val - W'(1);
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign zero = (cnt == '0);
endmodule

// File: rtl/fm_sweep_sequencer.sv
// fm_sweep_sequencer: linear FM carrier sweep (clk, rst, slave bus s); SWEEP_PINGPONG_EN adds a return sweep to start_freq
module fm_sweep_sequencer
  import fm_sweep_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  fm_sweep_sequencer_if.slave  s
);
  state_t        state, state_n;
  logic [FW-1:0] ctr_n, step_r, step_n, delta;
  logic [DW-1:0] dev_n;
  logic [CW-1:0] left_r, left_n, dwell_r, dwell_n, load_val;
  logic          load, zero, strobe_n;
`ifdef SWEEP_PINGPONG_EN
  logic [CW-1:0] num_r, num_n;
  phase_t        phase, phase_n;
  assign delta = (phase == PH_UP) ? step_r : -step_r;
`else
  assign delta = step_r;
`endif
  fm_dwell_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );
  always_comb begin
    state_n  = state;
    ctr_n    = s.ctr_ctrl;
    dev_n    = s.deviation;
    step_n   = step_r;
    left_n   = left_r;
    dwell_n  = dwell_r;
    strobe_n = 1'b0;
    load     = 1'b0;
    load_val = dwell_r;
`ifdef SWEEP_PINGPONG_EN
    num_n    = num_r;
    phase_n  = phase;
`endif
    if (state == S_IDLE) begin
      if (s.start && !s.abort) begin
        state_n  = S_DWELL;
        ctr_n    = s.start_freq;
        dev_n    = s.dev_in;
        step_n   = s.step_freq;
        left_n   = s.num_steps;
        dwell_n  = s.dwell;
        load     = 1'b1;
        load_val = s.dwell;
`ifdef SWEEP_PINGPONG_EN
        num_n    = s.num_steps;
        phase_n  = PH_UP;
`endif
      end
    end else if (s.abort || state == S_DONE) begin
      state_n = S_IDLE;
    end else if (zero) begin
      if (left_r != '0) begin
        ctr_n    = s.ctr_ctrl + delta;
        strobe_n = 1'b1;
        left_n   = left_r - CW'(1);
        load     = 1'b1;
      end
`ifdef SWEEP_PINGPONG_EN
      else if (phase == PH_UP && num_r != '0) begin
        ctr_n    = s.ctr_ctrl - step_r;
        strobe_n = 1'b1;
        left_n   = num_r - CW'(1);
        load     = 1'b1;
        phase_n  = PH_DOWN;
      end
`endif
      else state_n = S_DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      s.ctr_ctrl    <= '0;
      s.deviation   <= '0;
      s.busy        <= 1'b0;
      s.step_strobe <= 1'b0;
      s.done        <= 1'b0;
      step_r        <= '0;
      left_r        <= '0;
      dwell_r       <= '0;
`ifdef SWEEP_PINGPONG_EN
      num_r         <= '0;
      phase         <= PH_UP;
`endif
    end else begin
      state         <= state_n;
      s.ctr_ctrl    <= ctr_n;
      s.deviation   <= dev_n;
      s.busy        <= (state_n == S_DWELL);
      s.step_strobe <= strobe_n;
      s.done        <= (state_n == S_DONE);
      step_r        <= step_n;
      left_r        <= left_n;
      dwell_r       <= dwell_n;
`ifdef SWEEP_PINGPONG_EN
      num_r         <= num_n;
      phase         <= phase_n;
`endif
    end
  end
endmodule

// File: tb/tb_fm_sweep_sequencer.sv
// tb_fm_sweep_sequencer: directed vector table plus abort/reset/start corner sequences
module tb_fm_sweep_sequencer;
  import fm_sweep_pkg::*;
  typedef struct {
    logic [31:0] sf;
    logic [31:0] st;
    logic [15:0] ns;
    logic [15:0] dw;
    logic [7:0]  dev;
    int          busy;
    int          strobes;
    logic [31:0] last;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tv[4];
  fm_sweep_sequencer_if bus();
  fm_sweep_sequencer dut (.clk(clk), .rst(rst), .s(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] exp_freq(input vec_t v, input int k);
    int dw1, idx;
    dw1 = (v.dw == 16'd0) ? 1 : int'(v.dw);
    idx = k / dw1;
`ifdef SWEEP_PINGPONG_EN
    if (idx > int'(v.ns)) idx = 2 * int'(v.ns) - idx;
`endif
    return v.sf + 32'(idx) * v.st;
  endfunction
  task automatic launch(input vec_t v);
    bus.start_freq = v.sf;
    bus.step_freq  = v.st;
    bus.num_steps  = v.ns;
    bus.dwell      = v.dw;
    bus.dev_in     = v.dev;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.start_freq = ~v.sf;
    bus.step_freq  = 32'h0000_0001;
    bus.num_steps  = 16'd7;
    bus.dwell      = 16'd9;
    bus.dev_in     = ~v.dev;
  endtask
  task automatic run_vec(input vec_t v);
    int k, strobes, dw1;
    k = 0;
    strobes = 0;
    dw1 = (v.dw == 16'd0) ? 1 : int'(v.dw);
    launch(v);
    while (bus.busy && k < 200) begin
      bus.start = (k == 0);
      check("freq", bus.ctr_ctrl, exp_freq(v, k));
      check("dev", 32'(bus.deviation), 32'(v.dev));
      check("strobe", 32'(bus.step_strobe), (k > 0 && k % dw1 == 0) ? 32'd1 : 32'd0);
      if (bus.step_strobe) strobes++;
      k++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_cycles", 32'(k), 32'(v.busy));
    check("strobe_count", 32'(strobes), 32'(v.strobes));
    check("done_pulse", 32'(bus.done), 32'd1);
    check("last_freq", bus.ctr_ctrl, v.last);
    @(negedge clk);
    check("done_clear", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("hold_freq", bus.ctr_ctrl, v.last);
  endtask
  task automatic watch_quiet(input int n, input logic [31:0] freq);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.step_strobe || bus.ctr_ctrl !== freq) seen++;
    end
    check("quiet_idle", 32'(seen), 32'd0);
  endtask
  initial begin
`ifdef SWEEP_PINGPONG_EN
    tv[0] = '{32'h1000_0000, 32'h0010_0000, 16'd3, 16'd4, 8'h5A, 28, 6, 32'h1000_0000};
    tv[1] = '{32'h0008_0000, 32'hFFF0_0000, 16'd1, 16'd2, 8'h11, 6,  2, 32'h0008_0000};
    tv[2] = '{32'h1234_5678, 32'h0000_0100, 16'd0, 16'd0, 8'hC3, 1,  0, 32'h1234_5678};
    tv[3] = '{32'hFFFF_FFF0, 32'h0000_0010, 16'd2, 16'd1, 8'h7E, 5,  4, 32'hFFFF_FFF0};
`else
    tv[0] = '{32'h1000_0000, 32'h0010_0000, 16'd3, 16'd4, 8'h5A, 16, 3, 32'h1030_0000};
    tv[1] = '{32'h0008_0000, 32'hFFF0_0000, 16'd1, 16'd2, 8'h11, 4,  1, 32'hFFF8_0000};
    tv[2] = '{32'h1234_5678, 32'h0000_0100, 16'd0, 16'd0, 8'hC3, 1,  0, 32'h1234_5678};
    tv[3] = '{32'hFFFF_FFF0, 32'h0000_0010, 16'd2, 16'd1, 8'h7E, 3,  2, 32'h0000_0010};
`endif
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.start_freq = '0;
    bus.step_freq = '0;
    bus.num_steps = '0;
    bus.dwell = '0;
    bus.dev_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ctr", bus.ctr_ctrl, 32'd0);
    check("rst_dev", 32'(bus.deviation), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_strobe", 32'(bus.step_strobe), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) run_vec(tv[i]);
    launch(tv[0]);
    repeat (5) @(negedge clk);
    check("pre_abort_freq", bus.ctr_ctrl, 32'h1010_0000);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_strobe", 32'(bus.step_strobe), 32'd0);
    check("abort_freq", bus.ctr_ctrl, 32'h1010_0000);
    check("abort_dev", 32'(bus.deviation), 32'h5A);
    watch_quiet(20, 32'h1010_0000);
    bus.abort = 1'b1;
    watch_quiet(2, 32'h1010_0000);
    bus.start_freq = 32'hABCD_0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", 32'(bus.busy), 32'd0);
    check("start_abort_freq", bus.ctr_ctrl, 32'h1010_0000);
    watch_quiet(4, 32'h1010_0000);
    launch(tv[0]);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ctr", bus.ctr_ctrl, 32'd0);
    check("midrst_dev", 32'(bus.deviation), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    watch_quiet(20, 32'd0);
    run_vec(tv[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
